pkt_reg: RTL and testbench

//   Packet holding register between the packet receiver and the SPI byte

---
 rtl/pkt_reg_if.sv | 12 +
 rtl/pkt_reg.sv | 33 +++
 tb/tb_pkt_reg.sv | 112 +++++++++++
 3 files changed

// File: rtl/pkt_reg_if.sv
// pkt_reg_if: packet-load and byte-stream signals between the receiver, SPI side and pkt_reg
interface pkt_reg_if #(
    parameter int PACKET_SIZE = 64
);
    logic [PACKET_SIZE-1:0] din;
    logic                   pkt_rec;
    logic                   en;
    logic                   SPI_en;
    logic [7:0]             dout;
    modport master (output din, pkt_rec, en, SPI_en, input dout);
    modport slave  (input din, pkt_rec, en, SPI_en, output dout);
endinterface

// File: rtl/pkt_reg.sv
// pkt_reg: holds a received packet and streams it out one byte at a time, MSB byte first
module pkt_reg #(
    parameter int PACKET_SIZE = 64,
    parameter int BYTE_W      = 8
) (
    input logic       clk,
    input logic       rst,
    pkt_reg_if.slave  bus
);
    localparam int NBYTES = PACKET_SIZE / BYTE_W;
    localparam int CW     = $clog2(NBYTES + 1);

    logic [PACKET_SIZE-1:0] pkt_q;
    logic [CW-1:0]          cnt;
    logic                   adv;

    assign adv      = bus.en && bus.SPI_en && (cnt != '0);
    assign bus.dout = pkt_q[PACKET_SIZE-1 -: 8];

    // reset clears, a load beats a shift, a shift only happens while bytes remain
    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_q <= '0;
            cnt   <= '0;
        end else if (bus.pkt_rec) begin
            pkt_q <= bus.din;
            cnt   <= CW'(NBYTES);
        end else if (adv) begin
            pkt_q <= {pkt_q[PACKET_SIZE-9:0], 8'h00};
            cnt   <= cnt - 1'b1;
        end
    end
endmodule

// File: tb/tb_pkt_reg.sv
// tb_pkt_reg: directed checks of load, drain, gating, collision and reset for pkt_reg
module tb_pkt_reg;
    logic clk = 1'b0;
    logic rst;
    int   tests = 0;
    int   fails = 0;

    pkt_reg_if #(.PACKET_SIZE(64)) bus ();

    pkt_reg #(.PACKET_SIZE(64), .BYTE_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input string tag, input logic [7:0] exp);
        bus.en = 1'b1;
        tick();
        check({tag, "_edge"}, 64'(bus.dout), 64'(exp));
        bus.en = 1'b0;
        tick();
        check({tag, "_idle"}, 64'(bus.dout), 64'(exp));
    endtask

    logic [7:0] drain [8] = '{8'hAC, 8'hAB, 8'hAD, 8'hAB, 8'hAE, 8'hAB, 8'hAF, 8'h00};

    initial begin
        rst         = 1'b1;
        bus.din     = 64'hDEADBEEFCAFEF00D;
        bus.pkt_rec = 1'b0;
        bus.en      = 1'b0;
        bus.SPI_en  = 1'b1;
        tick();
        rst = 1'b0;
        check("reset_dout", 64'(bus.dout), 64'h00);
        check("reset_cnt", 64'(dut.cnt), 64'd0);
        pulse("empty_en0", 8'h00);
        pulse("empty_en1", 8'h00);

        bus.din     = 64'hABACABADABAEABAF;
        bus.pkt_rec = 1'b1;
        tick();
        bus.pkt_rec = 1'b0;
        bus.din     = '0;
        check("load_dout", 64'(bus.dout), 64'hAB);
        check("load_cnt", 64'(dut.cnt), 64'd8);

        bus.SPI_en = 1'b0;
        for (int i = 0; i < 3; i++) pulse("gated", 8'hAB);
        check("gated_cnt", 64'(dut.cnt), 64'd8);
        bus.SPI_en = 1'b1;

        for (int i = 0; i < 8; i++) pulse($sformatf("drain%0d", i), drain[i]);
        check("drained_cnt", 64'(dut.cnt), 64'd0);
        pulse("over0", 8'h00);
        pulse("over1", 8'h00);
        check("over_cnt", 64'(dut.cnt), 64'd0);

        bus.din     = 64'h1122334455667788;
        bus.pkt_rec = 1'b1;
        bus.en      = 1'b1;
        tick();
        bus.pkt_rec = 1'b0;
        bus.en      = 1'b0;
        check("collide_dout", 64'(bus.dout), 64'h11);
        check("collide_cnt", 64'(dut.cnt), 64'd8);
        pulse("after_collide", 8'h22);

        bus.din = 64'hFFFFFFFFFFFFFFFF;
        tick();
        check("din_ignored", 64'(bus.dout), 64'h22);
        pulse("mid1", 8'h33);
        pulse("mid2", 8'h44);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_dout", 64'(bus.dout), 64'h00);
        check("midrst_cnt", 64'(dut.cnt), 64'd0);
        pulse("postrst0", 8'h00);
        pulse("postrst1", 8'h00);

        bus.din     = 64'h1122334455667788;
        bus.pkt_rec = 1'b1;
        tick();
        bus.pkt_rec = 1'b0;
        bus.en      = 1'b1;
        tick();
        tick();
        tick();
        bus.en = 1'b0;
        check("level_dout", 64'(bus.dout), 64'h44);
        check("level_cnt", 64'(dut.cnt), 64'd5);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
